// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the divide controller: FSM states and DIV/REM op encodings.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // funct3[1:0] of the RV32M divide group
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundles the EX-stage request/result signals and the serial-divider handshake.
// Latency: n/a (wiring only).
// Backpressure: o_stall holds EX; i_div_busy holds off o_div_start.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
    logic             i_req_valid;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_rs1;
    logic [WIDTH-1:0] i_rs2;
    logic             i_flush;
    logic             o_stall;
    logic             o_result_valid;
    logic [WIDTH-1:0] o_result;
    logic             o_div_start;
    logic             o_div_signed;
    logic             o_div_flush;
    logic [WIDTH-1:0] o_div_dividend;
    logic [WIDTH-1:0] o_div_divisor;
    logic             i_div_busy;
    logic             i_div_valid;
    logic [WIDTH-1:0] i_div_quotient;
    logic [WIDTH-1:0] i_div_remainder;

    // slave: the controller; master: the EX stage plus divider side
    modport slave (
        input  i_req_valid, i_op, i_rs1, i_rs2, i_flush,
        input  i_div_busy, i_div_valid, i_div_quotient, i_div_remainder,
        output o_stall, o_result_valid, o_result,
        output o_div_start, o_div_signed, o_div_flush, o_div_dividend, o_div_divisor
    );

    modport master (
        output i_req_valid, i_op, i_rs1, i_rs2, i_flush,
        output i_div_busy, i_div_valid, i_div_quotient, i_div_remainder,
        input  o_stall, o_result_valid, o_result,
        input  o_div_start, o_div_signed, o_div_flush, o_div_dividend, o_div_divisor
    );
endinterface

// File: rtl/muldiv_ctrl_div_special.sv
// Detects divide-by-zero and signed overflow and supplies their fixed results.
// Latency: combinational.
// Backpressure: none.
module muldiv_ctrl_div_special #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             hit,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic div_zero;
    logic overflow;

    always_comb begin
        div_zero  = (divisor == '0);
        overflow  = is_signed && (dividend == MIN_VAL) && (divisor == '1);
        hit       = div_zero || overflow;
        // Divide-by-zero wins; the two cases cannot overlap anyway
        quotient  = div_zero ? '1 : MIN_VAL;
        remainder = div_zero ? dividend : '0;
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage controller sequencing DIV/DIVU/REM/REMU onto a serial divider; MULDIV_CTRL_FUSE_EN adds a one-entry result cache.
// Latency: special cases / cache hits 1 cycle; divider path = result strobe the cycle after i_div_valid.
// Backpressure: o_stall holds IF/ID/EX until the result strobe; o_div_start waits while i_div_busy.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);
    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] rs1_q, rs2_q, quo_q, rem_q;
    logic             sp_hit;
    logic [WIDTH-1:0] sp_quo, sp_rem;
    logic             req_take;
    logic             cache_hit;
    logic [WIDTH-1:0] cache_quo, cache_rem;
    logic             stall, result_vld, div_start, div_signed, div_flush;

    muldiv_ctrl_div_special #(.WIDTH(WIDTH)) u_div_special (
        .dividend  (bus.i_rs1),
        .divisor   (bus.i_rs2),
        .is_signed (op_is_signed(bus.i_op)),
        .hit       (sp_hit),
        .quotient  (sp_quo),
        .remainder (sp_rem)
    );

    assign req_take = (state == ST_IDLE) && bus.i_req_valid && !bus.i_flush;

`ifdef MULDIV_CTRL_FUSE_EN
    logic             c_vld, c_sgn;
    logic [WIDTH-1:0] c_rs1, c_rs2, c_quo, c_rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_vld <= 1'b0;
            c_sgn <= 1'b0;
            c_rs1 <= '0;
            c_rs2 <= '0;
            c_quo <= '0;
            c_rem <= '0;
        end else if (bus.i_flush) begin
            c_vld <= 1'b0;
        end else if (state == ST_WAIT && bus.i_div_valid) begin
            c_vld <= 1'b1;
            c_sgn <= op_is_signed(op_q);
            c_rs1 <= rs1_q;
            c_rs2 <= rs2_q;
            c_quo <= bus.i_div_quotient;
            c_rem <= bus.i_div_remainder;
        end
    end

    // DIV and REM of the same operands share one entry: both halves are kept
    assign cache_hit = c_vld && (c_rs1 == bus.i_rs1) && (c_rs2 == bus.i_rs2) &&
                       (c_sgn == op_is_signed(bus.i_op));
    assign cache_quo = c_quo;
    assign cache_rem = c_rem;
`else
    assign cache_hit = 1'b0;
    assign cache_quo = '0;
    assign cache_rem = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else if (req_take) begin
            op_q  <= bus.i_op;
            rs1_q <= bus.i_rs1;
            rs2_q <= bus.i_rs2;
            if (sp_hit) begin
                quo_q <= sp_quo;
                rem_q <= sp_rem;
            end else if (cache_hit) begin
                quo_q <= cache_quo;
                rem_q <= cache_rem;
            end
        end else if (state == ST_WAIT && bus.i_div_valid) begin
            quo_q <= bus.i_div_quotient;
            rem_q <= bus.i_div_remainder;
        end
    end

    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        result_vld = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_flush  = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = bus.i_req_valid;
                if (req_take) begin
                    state_nxt = (sp_hit || cache_hit) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                stall      = 1'b1;
                div_signed = op_is_signed(op_q);
                if (bus.i_flush) begin
                    div_flush = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!bus.i_div_busy) begin
                    div_start = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall      = 1'b1;
                div_signed = op_is_signed(op_q);
                if (bus.i_flush) begin
                    div_flush = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (bus.i_div_valid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                result_vld = !bus.i_flush;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // IDLE stall follows the request combinationally; keep it low under reset
        if (!reset) begin
            stall = 1'b0;
        end
    end

    assign bus.o_stall        = stall;
    assign bus.o_result_valid = result_vld;
    assign bus.o_result       = (state == ST_DONE) ? (op_is_rem(op_q) ? rem_q : quo_q) : '0;
    assign bus.o_div_start    = div_start;
    assign bus.o_div_signed   = div_signed;
    assign bus.o_div_flush    = div_flush;
    assign bus.o_div_dividend = rs1_q;
    assign bus.o_div_divisor  = rs2_q;
endmodule
